regfile_wb_scheduler: RTL
=========================

Name: regfile_wb_scheduler

Overview:
- Shares the single register-file write port (we3/wa3/wd3) between NREQ writeback requesters (e.g. ALU path, load unit, multi-cycle mul/div).
- Tracks outstanding writes per register with a scoreboard so decode can stall on RAW hazards.
- Sits between the writeback sources and the three-ported regfile. Its write-port outputs drive the regfile directly.

Parameters:
- NREQ, 2, number of writeback requesters; legal range 2..4.
- DATA_W, 32, write data width.
- ADDR_W, 5, register address width; 2**ADDR_W registers.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- resetn  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester writeback valid.
- req_ready  output  NREQ  per-requester grant, combinational, one-hot or zero.
- req_addr  input  NREQ*ADDR_W  destination register; requester i uses bits [i*ADDR_W +: ADDR_W].
- req_data  input  NREQ*DATA_W  writeback data, packed the same way.
- rsv_valid  input  1  issue stage reserves a destination register.
- rsv_addr  input  ADDR_W  register being reserved.
- rsv_ready  output  1  reservation accepted this cycle (combinational).
- chk_ra1, chk_ra2  input  ADDR_W  decode source registers to check.
- hazard1, hazard2  output  1  source has a pending write (combinational).
- we3  output  1  regfile write enable, registered.
- wa3  output  ADDR_W  regfile write address, registered.
- wd3  output  DATA_W  regfile write data, registered.

Behaviour:
Reset (resetn low, asynchronous):
- we3=0, wa3=0, wd3=0.
- All pending counters 0.
- RR pointer = NREQ-1, so requester 0 has priority first.
- Reset mid-operation discards any in-flight write and all reservations. No we3 pulse follows reset release.

Arbitration:
- Round-robin. Search starts at index (ptr+1) mod NREQ; the first i with req_valid[i]=1 gets req_ready[i]=1. All other ready bits are 0.
- The handshake completes when valid and ready are both 1 at a rising edge.
- On handshake: ptr <= granted index.
- With no valid requester, ptr holds and all ready bits are 0.
- req_ready never depends on req_ready (no loops). It depends only on req_valid and ptr.
- One grant per cycle at most, so sustained throughput is 1 write/cycle.

Write port (latency 1):
- Handshake at edge E sets we3=1, wa3=req_addr[i], wd3=req_data[i] after E.
- Cycle with no handshake: we3=0 after the edge. wa3 and wd3 hold their last value.
- A handshake with addr 0 is accepted (ready=1), but we3 stays 0 and no counter is touched.

Scoreboard (2-bit counter per register; register 0 is never tracked):
- Increment: rsv_valid & rsv_ready & rsv_addr!=0 at an edge.
- Decrement: we3=1 & wa3!=0 at an edge, i.e. the edge on which the regfile commits the write.
- Increment and decrement of the same register at the same edge: counter unchanged.
- Saturation: rsv_ready = !(count[rsv_addr]==3). rsv_ready is 1 for rsv_addr=0.
- Underflow: decrement at count 0 is ignored (count stays 0). This is a protocol error; the bench asserts it never happens.
- hazardN = (chk_raN != 0) && (count[chk_raN] != 0).
- hazard stays 1 through the cycle in which we3 is high. It drops after that edge, when the regfile already holds the new value.

Test Plan:
- Reset: hold resetn=0 with req_valid=2'b11 -> req_ready=2'b00 is not required, but we3=0, hazard1=hazard2=0, wa3=0, wd3=0. After release, first grant goes to req 0.
- Round robin: both valid continuously, addr0=3/data0=0xAAAA0000, addr1=4/data1=0x0000BBBB -> grants alternate 0,1,0,1. we3 stays high, with wa3 sequence 3,4,3,4 one cycle behind each grant.
- Scoreboard: rsv reg 7, then chk_ra1=7 -> hazard1=1. Requester 1 writes reg 7 -> hazard1 stays 1 during the we3 cycle and is 0 the next cycle.
- WAW/saturation: reserve reg 9 three times -> 4th rsv_ready=0. One commit to reg 9 -> rsv_ready=1. Simultaneous rsv+commit to reg 9 -> count stays 2.
- Register 0: rsv_addr=0 and req_addr=0 -> rsv_ready=1, req_ready=1, we3 stays 0, chk_ra1=0 -> hazard1=0.
- Async reset mid-write: pull resetn low while we3=1 and count[5]=2 -> we3=0 immediately, hazard on reg 5 = 0. After release there is no stale write.

Source files
------------

// File: rtl/regfile_wb_scheduler.sv
// Writeback arbiter for the shared regfile write port,
// with a per-register pending-write scoreboard for RAW stalls.
module regfile_wb_scheduler #(
  parameter int NREQ   = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_data,
  input  logic                   rsv_valid,
  input  logic [ADDR_W-1:0]      rsv_addr,
  output logic                   rsv_ready,
  input  logic [ADDR_W-1:0]      chk_ra1,
  input  logic [ADDR_W-1:0]      chk_ra2,
  output logic                   hazard1,
  output logic                   hazard2,
  output logic                   we3,
  output logic [ADDR_W-1:0]      wa3,
  output logic [DATA_W-1:0]      wd3
);

  localparam int PW   = (NREQ > 2) ? 2 : 1;
  localparam int NREG = 2 ** ADDR_W;

  logic [PW-1:0]     r_ptr;
  logic [PW-1:0]     w_gidx;
  logic              w_grant;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              w_inc;
  logic              w_dec;
  logic [1:0]        r_cnt [NREG];

  // Round-robin search starting one past the last granted index
  always_comb begin
    w_gidx    = '0;
    w_grant   = 1'b0;
    req_ready = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!w_grant && req_valid[(int'(r_ptr) + k) % NREQ]) begin
        w_grant = 1'b1;
        w_gidx  = PW'((int'(r_ptr) + k) % NREQ);
      end
    end
    if (w_grant) req_ready[w_gidx] = 1'b1;
  end

  assign w_addr = req_addr[w_gidx*ADDR_W +: ADDR_W];
  assign w_data = req_data[w_gidx*DATA_W +: DATA_W];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      we3   <= 1'b0;
      wa3   <= '0;
      wd3   <= '0;
      r_ptr <= PW'(NREQ - 1);
    end else begin
      we3 <= w_grant && (w_addr != '0);
      if (w_grant) begin
        wa3   <= w_addr;
        wd3   <= w_data;
        r_ptr <= w_gidx;
      end
    end
  end

  assign rsv_ready = (r_cnt[rsv_addr] != 2'd3);
  assign w_inc = rsv_valid && rsv_ready && (rsv_addr != '0);
  assign w_dec = we3 && (wa3 != '0);

  // Entry 0 is only ever cleared, so x0 never reports a hazard
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NREG; i++) r_cnt[i] <= 2'd0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (w_inc && rsv_addr == ADDR_W'(i)
            && !(w_dec && wa3 == ADDR_W'(i))) begin
          r_cnt[i] <= r_cnt[i] + 2'd1;
        end else if (w_dec && wa3 == ADDR_W'(i)
                     && !(w_inc && rsv_addr == ADDR_W'(i))
                     && r_cnt[i] != 2'd0) begin
          r_cnt[i] <= r_cnt[i] - 2'd1;
        end
      end
    end
  end

  assign hazard1 = (chk_ra1 != '0) && (r_cnt[chk_ra1] != 2'd0);
  assign hazard2 = (chk_ra2 != '0) && (r_cnt[chk_ra2] != 2'd0);

endmodule
